// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter and sequencer for the single shared memory port.
// Round-robin grant in IDLE, REQ/WAIT handshake to memory, watchdog abort on missing response.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned TO_W    = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_valid,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_ready,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_err,
   input  logic                lsu_valid,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_ready,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

   state_t          state;
   logic            owner;       // 0 = IFU, 1 = LSU
   logic            last_grant;  // 0 = IFU, 1 = LSU
   logic [TO_W-1:0] wd_cnt;
   logic            grant_ifu;
   logic            grant_lsu;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (!rst && state == IDLE) begin
         if (ifu_valid && (!lsu_valid || last_grant))
            grant_ifu = 1'b1;
         else if (lsu_valid)
            grant_lsu = 1'b1;
      end
   end

   assign ifu_ready = grant_ifu;
   assign lsu_ready = grant_lsu;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         owner          <= 1'b0;
         last_grant     <= 1'b1;
         wd_cnt         <= '0;
         mem_req_valid  <= 1'b0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_resp_valid <= 1'b0;
         ifu_rdata      <= '0;
         ifu_err        <= 1'b0;
         lsu_resp_valid <= 1'b0;
         lsu_rdata      <= '0;
         lsu_err        <= 1'b0;
      end else begin
         ifu_resp_valid <= 1'b0;
         ifu_rdata      <= '0;
         ifu_err        <= 1'b0;
         lsu_resp_valid <= 1'b0;
         lsu_rdata      <= '0;
         lsu_err        <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_ifu || grant_lsu) begin
                  owner         <= grant_lsu;
                  last_grant    <= grant_lsu;
                  mem_addr      <= grant_lsu ? lsu_addr : ifu_addr;
                  mem_wen       <= grant_lsu & lsu_wen;
                  mem_wdata     <= grant_lsu ? lsu_wdata : '0;
                  mem_wmask     <= grant_lsu ? lsu_wmask : '0;
                  mem_req_valid <= 1'b1;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  wd_cnt        <= '0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               // A response arriving on the timeout cycle takes priority over the abort.
               if (mem_resp_valid) begin
                  if (owner) begin
                     lsu_resp_valid <= 1'b1;
                     lsu_rdata      <= mem_wen ? '0 : mem_rdata;
                  end else begin
                     ifu_resp_valid <= 1'b1;
                     ifu_rdata      <= mem_rdata;
                  end
                  state <= IDLE;
               end else if (wd_cnt == TO_LIMIT) begin
                  if (owner) begin
                     lsu_resp_valid <= 1'b1;
                     lsu_err        <= 1'b1;
                  end else begin
                     ifu_resp_valid <= 1'b1;
                     ifu_err        <= 1'b1;
                  end
                  state <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder model, grant-time scoreboard of expected
// responses, and per-scenario tasks with inline cycle-accurate checks.
module tb_mem_arbiter;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned TO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            ifu_valid, ifu_ready, ifu_resp_valid, ifu_err;
   logic [AW-1:0]   ifu_addr;
   logic [DW-1:0]   ifu_rdata;
   logic            lsu_valid, lsu_wen, lsu_ready, lsu_resp_valid, lsu_err;
   logic [AW-1:0]   lsu_addr;
   logic [DW-1:0]   lsu_wdata, lsu_rdata;
   logic [DW/8-1:0] lsu_wmask;
   logic            mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata, mem_rdata;
   logic [DW/8-1:0] mem_wmask;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TO_W(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
      .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
      .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_ready(lsu_ready),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic          lsu;
      logic          err;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   resp_count = 0;
   int   cfg_ready_delay = 0;
   int   cfg_resp_delay = 0;
   bit   cfg_no_resp = 1'b0;
   bit   force_resp = 1'b0;

   function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
      if (a == 64'h8000_0000) return 64'h0000_0413;
      return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
   endfunction

   function automatic logic exp_err();
      return cfg_no_resp || (cfg_resp_delay > int'(TO));
   endfunction

   // Memory responder: handshake after cfg_ready_delay REQ cycles, respond after cfg_resp_delay WAIT cycles.
   task automatic mem_model();
      logic          in_wait;
      int            req_cnt, wait_cnt;
      logic [AW-1:0] hs_addr;
      in_wait = 1'b0; req_cnt = 0; wait_cnt = 0; hs_addr = '0;
      forever begin
         @(posedge clk); #2;
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
         if (rst) begin
            in_wait = 1'b0; req_cnt = 0;
         end else begin
            if (in_wait) begin
               if (!cfg_no_resp && wait_cnt == cfg_resp_delay) begin
                  mem_resp_valid = 1'b1; mem_rdata = rd_data(hs_addr); in_wait = 1'b0;
               end else wait_cnt++;
            end
            if (force_resp) begin
               mem_resp_valid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; force_resp = 1'b0;
            end
            if (mem_req_valid) begin
               if (req_cnt == cfg_ready_delay) begin
                  mem_req_ready = 1'b1; hs_addr = mem_addr; req_cnt = 0; in_wait = 1'b1; wait_cnt = 0;
               end else req_cnt++;
            end
         end
      end
   endtask

   task automatic monitor();
      exp_t e, obs;
      forever begin
         @(negedge clk);
         if (ifu_ready && lsu_ready) begin
            n_cmp++; n_bad++; $display("FAIL ready_excl: both readies high, required at most one");
         end
         if (ifu_ready) begin
            e.lsu = 1'b0; e.err = exp_err(); e.data = e.err ? '0 : rd_data(ifu_addr);
            sb.push_back(e);
         end
         if (lsu_ready) begin
            e.lsu = 1'b1; e.err = exp_err(); e.data = (e.err || lsu_wen) ? '0 : rd_data(lsu_addr);
            sb.push_back(e);
         end
         if (ifu_resp_valid || lsu_resp_valid) begin
            resp_count++;
            n_cmp++;
            if (ifu_resp_valid && lsu_resp_valid) begin
               n_bad++; $display("FAIL resp_excl: both resp_valid high, required at most one");
            end else if (sb.size() == 0) begin
               n_bad++; $display("FAIL resp_unexpected: lsu=%0b with no granted transaction outstanding", lsu_resp_valid);
            end else begin
               e = sb.pop_front();
               obs.lsu  = lsu_resp_valid;
               obs.err  = lsu_resp_valid ? lsu_err : ifu_err;
               obs.data = lsu_resp_valid ? lsu_rdata : ifu_rdata;
               if (obs !== e) begin
                  n_bad++;
                  $display("FAIL resp: got lsu=%0b err=%0b data=%h, required lsu=%0b err=%0b data=%h",
                           obs.lsu, obs.err, obs.data, e.lsu, e.err, e.data);
               end
            end
         end
      end
   endtask

   task automatic drain();
      int c = 0;
      while (sb.size() != 0 && c < 40) begin @(negedge clk); c++; end
      if (sb.size() != 0) begin
         n_cmp++; n_bad++; $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; ifu_valid = 1'b1; lsu_valid = 1'b1;
      ifu_addr = 64'h8000_0040; lsu_addr = 64'h8000_2000; lsu_wen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ({ifu_ready, lsu_ready, ifu_resp_valid, lsu_resp_valid, ifu_err, lsu_err, mem_req_valid, mem_wen} !== 8'h00
             || ifu_rdata !== '0 || lsu_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0 || mem_wmask !== '0) begin
            n_bad++; $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
         end
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ifu_ready, lsu_ready} !== 2'b10) begin
         n_bad++; $display("FAIL reset_first_tie: ready ifu/lsu=%b, required 10", {ifu_ready, lsu_ready});
      end
      @(posedge clk); #1 ifu_valid = 1'b0; lsu_valid = 1'b0;
      drain();
   endtask

   task automatic test_ifu_read();
      @(posedge clk); #1 ifu_valid = 1'b1; ifu_addr = 64'h8000_0000;
      @(negedge clk);
      n_cmp++;
      if (ifu_ready !== 1'b1) begin n_bad++; $display("FAIL ifu_ready_c0: got %b, required 1", ifu_ready); end
      @(posedge clk); #1 ifu_valid = 1'b0; ifu_addr = '1;
      @(negedge clk);
      n_cmp++;
      if ({mem_req_valid, mem_wen, mem_addr, mem_wmask} !== {1'b1, 1'b0, 64'h8000_0000, 8'h00}) begin
         n_bad++; $display("FAIL ifu_req_c1: valid=%b wen=%b addr=%h wmask=%h, required 1 0 80000000 00",
                           mem_req_valid, mem_wen, mem_addr, mem_wmask);
      end
      @(negedge clk);
      n_cmp++;
      if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin
         n_bad++; $display("FAIL ifu_wait_c2: req_valid/resp_valid=%b, required 00", {mem_req_valid, ifu_resp_valid});
      end
      @(negedge clk);
      n_cmp++;
      if ({ifu_resp_valid, ifu_err, ifu_rdata} !== {1'b1, 1'b0, 64'h0000_0413}) begin
         n_bad++; $display("FAIL ifu_resp_c3: valid=%b err=%b data=%h, required 1 0 413",
                           ifu_resp_valid, ifu_err, ifu_rdata);
      end
      drain();
   endtask

   task automatic test_round_robin();
      int   ng = 0;
      int   last_c = 0;
      logic exp_lsu = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ifu_valid = 1'b1; lsu_valid = 1'b1; lsu_wen = 1'b0;
      ifu_addr = 64'h8000_0400; lsu_addr = 64'h8000_0800;
      for (int c = 0; c < 20 && ng < 4; c++) begin
         @(negedge clk);
         if (ifu_ready || lsu_ready) begin
            n_cmp++;
            if (lsu_ready !== exp_lsu) begin
               n_bad++; $display("FAIL rr_order: grant %0d went to lsu=%b, required lsu=%b", ng, lsu_ready, exp_lsu);
            end
            if (ng > 0) begin
               n_cmp++;
               if (c - last_c != 3) begin
                  n_bad++; $display("FAIL rr_spacing: %0d cycles between grants, required 3", c - last_c);
               end
            end
            last_c = c; ng++; exp_lsu = ~exp_lsu;
         end
      end
      n_cmp++;
      if (ng != 4) begin n_bad++; $display("FAIL rr_count: %0d grants seen, required 4", ng); end
      @(posedge clk); #1 ifu_valid = 1'b0; lsu_valid = 1'b0;
      drain();
   endtask

   task automatic test_lsu_write();
      cfg_ready_delay = 4;
      @(posedge clk); #1
      lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1000;
      lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
      @(negedge clk);
      n_cmp++;
      if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL lsu_ready_c0: got %b, required 1", lsu_ready); end
      @(posedge clk); #1
      lsu_valid = 1'b0; lsu_addr = '0; lsu_wdata = '1; lsu_wmask = '1; lsu_wen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask}
             !== {1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F}) begin
            n_bad++; $display("FAIL lsu_req_hold[%0d]: valid=%b wen=%b addr=%h wdata=%h wmask=%h, required 1 1 80001000 deadbeef 0f",
                              i, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({mem_req_valid, lsu_resp_valid} !== 2'b00) begin
         n_bad++; $display("FAIL lsu_wait: req_valid/resp_valid=%b, required 00", {mem_req_valid, lsu_resp_valid});
      end
      @(negedge clk);
      n_cmp++;
      if ({lsu_resp_valid, lsu_err, lsu_rdata} !== {1'b1, 1'b0, 64'h0}) begin
         n_bad++; $display("FAIL lsu_write_resp: valid=%b err=%b data=%h, required 1 0 0",
                           lsu_resp_valid, lsu_err, lsu_rdata);
      end
      cfg_ready_delay = 0;
      drain();
   endtask

   task automatic test_timeout();
      int cnt;
      cfg_no_resp = 1'b1;
      @(posedge clk); #1 lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_3000;
      @(negedge clk);
      n_cmp++;
      if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready: got %b, required 1", lsu_ready); end
      @(posedge clk); #1 lsu_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if (lsu_resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL to_early: resp_valid=%b at cycle %0d, required 0", lsu_resp_valid, c);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({lsu_resp_valid, lsu_err, lsu_rdata} !== {1'b1, 1'b1, 64'h0}) begin
         n_bad++; $display("FAIL to_resp: valid=%b err=%b data=%h, required 1 1 0",
                           lsu_resp_valid, lsu_err, lsu_rdata);
      end
      @(posedge clk); #1 force_resp = 1'b1; cfg_no_resp = 1'b0; cnt = resp_count;
      repeat (4) @(negedge clk);
      #1;
      n_cmp++;
      if (resp_count != cnt) begin
         n_bad++; $display("FAIL to_late_resp: %0d extra pulses, required 0", resp_count - cnt);
      end
      drain();
   endtask

   task automatic test_reset_mid_wait();
      int cnt;
      int c;
      cfg_no_resp = 1'b1;
      @(posedge clk); #1 ifu_valid = 1'b1; ifu_addr = 64'h8000_0100;
      @(negedge clk);
      n_cmp++;
      if (ifu_ready !== 1'b1) begin n_bad++; $display("FAIL rmw_ready: got %b, required 1", ifu_ready); end
      @(posedge clk); #1 ifu_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_ready} !== 4'b0000) begin
         n_bad++; $display("FAIL rmw_in_reset: req/ifu_resp/lsu_resp/ready=%b, required 0000",
                           {mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_ready});
      end
      @(posedge clk); #1
      rst = 1'b0; force_resp = 1'b1; cfg_no_resp = 1'b0; sb.delete(); cnt = resp_count;
      repeat (4) @(negedge clk);
      #1;
      n_cmp++;
      if (resp_count != cnt) begin
         n_bad++; $display("FAIL rmw_ghost: %0d pulses after reset, required 0", resp_count - cnt);
      end
      @(posedge clk); #1 ifu_valid = 1'b1; ifu_addr = 64'h8000_0200;
      @(negedge clk);
      n_cmp++;
      if (ifu_ready !== 1'b1) begin n_bad++; $display("FAIL rmw_next_ready: got %b, required 1", ifu_ready); end
      @(posedge clk); #1 ifu_valid = 1'b0;
      c = 0;
      while (ifu_resp_valid !== 1'b1 && c < 10) begin @(negedge clk); c++; end
      if (ifu_resp_valid !== 1'b1) begin
         n_cmp++; n_bad++; $display("FAIL rmw_next_resp: no response within 10 cycles, required one");
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int   sel;
      logic g_i, g_l;
      for (int i = 0; i < 10; i++) begin
         cfg_ready_delay = $urandom_range(0, 2);
         cfg_resp_delay  = (i == 0) ? 4 : (i == 1) ? 5 : $urandom_range(0, 5);
         sel = (i < 2) ? 2 : $urandom_range(0, 2);
         @(posedge clk); #1
         ifu_valid = (sel != 1); lsu_valid = (sel != 0);
         ifu_addr  = {32'h0, $urandom}; lsu_addr = {32'h0, $urandom};
         lsu_wen   = 1'($urandom_range(0, 1));
         lsu_wdata = {$urandom, $urandom}; lsu_wmask = 8'($urandom);
         for (int c = 0; c < 60 && (ifu_valid || lsu_valid); c++) begin
            @(negedge clk); g_i = ifu_ready; g_l = lsu_ready;
            @(posedge clk); #1
            if (g_i) ifu_valid = 1'b0;
            if (g_l) lsu_valid = 1'b0;
         end
         if (ifu_valid || lsu_valid) begin
            n_cmp++; n_bad++; $display("FAIL b2b_grant[%0d]: requester never granted, required grant", i);
            ifu_valid = 1'b0; lsu_valid = 1'b0;
         end
         drain();
      end
      cfg_resp_delay = 0; cfg_ready_delay = 0;
   endtask

   initial begin
      rst = 1'b1;
      ifu_valid = 1'b0; ifu_addr = '0;
      lsu_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
      fork
         mem_model();
         monitor();
      join_none
      test_reset();
      test_ifu_read();
      test_round_robin();
      test_lsu_write();
      test_timeout();
      test_reset_mid_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory-port arbiter and sequencer for the single-cycle core. It shares the one physical memory port (the DPI pmem bridge) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It grants one transaction at a time with round-robin fairness, drives the memory-side request/response handshake, and returns the response to the owning requester. A watchdog aborts transactions whose memory response never arrives.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; the write mask is DATA_W/8 bits
- TO_W, 8, watchdog counter width
- TIMEOUT, 255, number of WAIT cycles before abort; must be < 2^TO_W and ≥ 1

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- ifu_valid  in  1  IFU read request
- ifu_addr  in  ADDR_W  IFU read address
- ifu_ready  out  1  IFU request accepted this cycle
- ifu_resp_valid  out  1  one-cycle pulse; ifu_rdata is valid
- ifu_rdata  out  DATA_W  fetched data
- ifu_err  out  1  qualifies ifu_resp_valid; transaction timed out
- lsu_valid  in  1  LSU request
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte enables for writes
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_resp_valid  out  1  one-cycle pulse; write acknowledge or read data valid
- lsu_rdata  out  DATA_W  load data; 0 for writes
- lsu_err  out  1  qualifies lsu_resp_valid; transaction timed out
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

## Operation
- The state machine has three states: IDLE, REQ and WAIT. Registers: owner (0 = IFU, 1 = LSU), last_grant, the latched request fields and the watchdog count.
- **IDLE**
  - If any valid is high, arbitrate. When only one requester is valid, it wins. When both are valid, the requester not equal to last_grant wins.
  - The winner's ready is asserted combinationally in the same cycle. The address, wen, wdata and wmask are latched; IFU requests latch wen=0 and wmask=0.
  - On a grant: owner and last_grant are set to the winner, and the state moves to REQ.
  - The losing ready stays 0. The loser must hold its valid.
- **REQ**
  - mem_req_valid=1 with the latched fields held stable.
  - On mem_req_ready=1: move to WAIT and clear the watchdog.
- **WAIT**
  - mem_req_valid=0. The watchdog increments each cycle.
  - On mem_resp_valid=1: pulse the owner's resp_valid for 1 cycle with err=0 and move to IDLE.
    - Owner IFU: ifu_rdata = mem_rdata.
    - Owner LSU read: lsu_rdata = mem_rdata.
    - Owner LSU write: lsu_rdata = 0.
  - If the watchdog reaches TIMEOUT without a response: pulse the owner's resp_valid with err=1 and rdata=0, then move to IDLE.
  - A response and the timeout in the same cycle: the response wins with err=0.
- mem_resp_valid in IDLE or REQ is ignored. This covers late responses after a timeout or reset.
- Requesters may drop valid after their ready cycle. No ready is ever asserted outside IDLE.
- **Reset:** state=IDLE, last_grant=LSU (so the IFU wins the first tie), owner=IFU, latched fields=0, watchdog=0.
  - All outputs are 0 during and immediately after reset.
  - A reset in REQ or WAIT abandons the transaction with no response pulse.

## Timing
- All resp_valid, err and rdata outputs are registered. ready is combinational from state and the valids.
- Minimum transaction, with mem_req_ready=1 and mem_resp_valid=1 on the first possible cycles:
  - cycle 0: ready.
  - cycle 1: REQ.
  - cycle 2: WAIT, response sampled.
  - cycle 3: resp_valid high and state IDLE. A new grant may occur in this same cycle.
- Throughput is one transaction per 3 cycles at best.
- A timeout response appears TIMEOUT+1 cycles after entering WAIT.
- At most one of ifu_resp_valid or lsu_resp_valid is high in any cycle. Each is high for exactly 1 cycle per granted transaction.

## Test plan
- **Reset:** hold rst 3 cycles with both valids high -> all outputs 0. On the first cycle after rst falls, ifu_ready=1 and lsu_ready=0.
- **IFU read:** ifu_addr=0x80000000, memory ready and responds on first opportunity with 0x00000413 -> ifu_ready at cycle 0, mem_req_valid at cycle 1 with mem_addr=0x80000000 and mem_wen=0, ifu_resp_valid at cycle 3 with ifu_rdata=0x00000413 and ifu_err=0.
- **Round-robin:** both valids held continuously -> grant order IFU, LSU, IFU, LSU. No ready is asserted while the state is not IDLE.
- **LSU write:** addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, memory holds mem_req_ready low 4 cycles -> mem fields stable for all 5 REQ cycles. lsu_resp_valid follows with lsu_rdata=0.
- **Timeout:** TIMEOUT=4, memory never responds -> lsu_resp_valid=1 and lsu_err=1 five cycles after entering WAIT. A mem_resp_valid injected one cycle later is ignored, and no extra pulse occurs.
- **Reset mid-WAIT:** assert rst during WAIT, then inject mem_resp_valid after reset -> no resp_valid pulse. The next request proceeds normally.
